// File: rtl/io_bridge.sv
// io_bridge: cpu byte bus to RAM, UART TX FIFO, RX byte and cycle counter.
// Define IO_BRIDGE_TX_BYPASS_EN to send a byte straight to an idle UART, skipping the FIFO.
module io_bridge #(
    parameter int TX_FIFO_DEPTH = 16,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_done
);
    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(TX_FIFO_DEPTH - FULL_MARGIN);
    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(TX_FIFO_DEPTH);

    logic          io_sel, rd, wr, at_rx, at_cnt, cnt_lo, stop_w;
    logic          push_req, push, pop, byp, empty, full;
    logic [7:0]    push_data, io_byte, io_q, last_q;
    logic [7:0]    mem [TX_FIFO_DEPTH];
    logic [AW-1:0] rp, wp;
    logic [AW:0]   count;
    logic [31:0]   cnt, snap;
    logic          src_io, rdy_q, stop_pending, done, ovf;
    logic          unused_hi;

    assign unused_hi = ^cpu_a[31:18];
    assign io_sel    = cpu_a[17:16] == 2'b11;
    assign rd        = rdy_in & ~cpu_wr;
    assign wr        = rdy_in & cpu_wr;
    assign at_rx     = io_sel & (cpu_a[15:0] == 16'h0000);
    assign at_cnt    = io_sel & (cpu_a[15:2] == 14'd1);
    assign cnt_lo    = at_cnt & (cpu_a[1:0] == 2'b00);

    assign ram_a   = cpu_a[16:0];
    assign ram_din = cpu_dout;
    assign ram_we  = wr & ~io_sel;

    assign stop_w    = wr & cnt_lo & ~stop_pending;
    assign push_req  = stop_w | (wr & at_rx & ~stop_pending & (cpu_dout != 8'h00));
    assign push_data = stop_w ? 8'h00 : cpu_dout;
    assign empty     = count == '0;
    assign full      = count == DEPTH_LVL;
    assign pop       = ~empty & tx_ready;
`ifdef IO_BRIDGE_TX_BYPASS_EN
    assign byp = push_req & ~stop_w & empty & tx_ready;
`else
    assign byp = 1'b0;
`endif
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push           = push_req & ~byp & (~full | pop);
    assign tx_valid       = ~empty | byp;
    assign tx_data        = byp ? cpu_dout : mem[rp];
    assign io_buffer_full = count >= FULL_LVL;
    assign program_done   = done;

    assign rx_pop  = rd & at_rx & rx_valid;
    assign io_byte = at_rx  ? (rx_valid ? rx_data : 8'h00) :
                     cnt_lo ? cnt[7:0] :
                     at_cnt ? snap[{cpu_a[1:0], 3'b000} +: 8] : 8'h00;
    // After a stalled cycle the returned byte is replayed rather than re-sampled
    assign cpu_din = rdy_q ? (src_io ? io_q : ram_dout) : last_q;

    always_ff @(posedge clk_in)
        if (push) mem[wp] <= push_data;

    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            rp           <= '0;
            wp           <= '0;
            count        <= '0;
            stop_pending <= 1'b0;
            done         <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count        <= count + (AW+1)'(push) - (AW+1)'(pop);
            stop_pending <= stop_pending | stop_w;
            done         <= done | (stop_pending & empty);
            ovf          <= ovf | (push_req & ~byp & full & ~pop);
        end

    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            cnt    <= '0;
            snap   <= '0;
            src_io <= 1'b0;
            io_q   <= '0;
            rdy_q  <= 1'b0;
            last_q <= '0;
        end else begin
            rdy_q  <= rdy_in;
            last_q <= cpu_din;
            if (rdy_in) begin
                cnt    <= cnt + 32'd1;
                src_io <= rd & io_sel;
            end
            if (rd) io_q <= io_byte;
            if (rd & cnt_lo) snap <= cnt;
        end
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: randomized and directed checks of io_bridge against a queue-based model.
module tb_io_bridge;
    logic        clk_in = 0, rst_in = 0, rdy_in = 0, cpu_wr = 0;
    logic [31:0] cpu_a = 0;
    logic [7:0]  cpu_dout = 0, ram_dout = 0, rx_data = 0;
    logic        tx_ready = 0, rx_valid = 0;
    logic [7:0]  cpu_din, tx_data, ram_din;
    logic [16:0] ram_a;
    logic        io_buffer_full, ram_we, tx_valid, rx_pop, program_done;

    int errors = 0, checks = 0;

    io_bridge dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .cpu_a(cpu_a),
        .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .io_buffer_full(io_buffer_full), .ram_a(ram_a), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_pop(rx_pop), .program_done(program_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: FIFO contents as a queue, counter as a plain count of enabled cycles
    typedef enum {K_NONE, K_RAM, K_IO, K_HOLD} kind_t;
    logic [7:0]  q[$];
    logic [7:0]  txlog[$];
    int unsigned mcnt, msnap;
    logic        mstop, mdone, movf, mlast_ok;
    logic [7:0]  mio, mlast;
    kind_t       mkind;
    logic [17:0] a18;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            q.delete();
            mcnt = 0; msnap = 0; mstop = 0; mdone = 0; movf = 0;
            mkind = K_HOLD; mlast = 0; mlast_ok = 1; mio = 0;
        end else begin
            mdone = mdone | (mstop && q.size() == 0);
            if (mkind == K_RAM) begin mlast = ram_dout; mlast_ok = 1; end
            else if (mkind == K_IO) begin mlast = mio; mlast_ok = 1; end
            else if (mkind == K_NONE) mlast_ok = 0;
            if (q.size() != 0 && tx_ready) txlog.push_back(q.pop_front());
            if (rdy_in) begin
                a18 = cpu_a[17:0];
                if (cpu_wr) begin
                    if (!mstop && ((a18 == 18'h30000 && cpu_dout != 0) || a18 == 18'h30004)) begin
                        if (q.size() < 16) q.push_back(a18 == 18'h30004 ? 8'h00 : cpu_dout);
                        else movf = 1;
                        if (a18 == 18'h30004) mstop = 1;
                    end
                    mkind = K_NONE;
                end else if (a18[17:16] == 2'b11) begin
                    mkind = K_IO;
                    if (a18 == 18'h30000) mio = rx_valid ? rx_data : 8'h00;
                    else if (a18 >= 18'h30004 && a18 <= 18'h30007) begin
                        if (a18 == 18'h30004) msnap = mcnt;
                        mio = 8'(msnap >> (8 * a18[1:0]));
                    end else mio = 8'h00;
                end else mkind = K_RAM;
                mcnt++;
            end else mkind = K_HOLD;
        end
    end

    always @(negedge clk_in) begin
        chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
        chk("io_buffer_full", 32'(io_buffer_full), 32'(q.size() >= 14));
        chk("program_done", 32'(program_done), 32'(mdone));
        chk("ovf", 32'(dut.ovf), 32'(movf));
        chk("rx_pop", 32'(rx_pop), 32'(rdy_in && !cpu_wr && cpu_a[17:0] == 18'h30000 && rx_valid));
        chk("ram_we", 32'(ram_we), 32'(rdy_in && cpu_wr && cpu_a[17:16] != 2'b11));
        chk("ram_a", 32'(ram_a), 32'(cpu_a[16:0]));
        if (mkind == K_RAM) chk("cpu_din_ram", 32'(cpu_din), 32'(ram_dout));
        else if (mkind == K_IO) chk("cpu_din_io", 32'(cpu_din), 32'(mio));
        else if (mkind == K_HOLD && mlast_ok) chk("cpu_din_hold", 32'(cpu_din), 32'(mlast));
    end

    task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d);
        @(posedge clk_in); #2;
        rdy_in = r; cpu_a = a; cpu_wr = w; cpu_dout = d;
    endtask

    task automatic idle();
        drive(1, 32'h0, 0, 8'h00);
    endtask

    task automatic do_reset();
        @(posedge clk_in); #2;
        rst_in = 0; rdy_in = 0; cpu_wr = 0; cpu_a = 0; cpu_dout = 0; rx_valid = 0;
        @(posedge clk_in); #2;
        rst_in = 1;
    endtask

    logic [7:0] b0, b1, b2, b3;
    int         n;
    int unsigned r;

    initial begin
        do_reset();
        // 1: reset in the middle of a drain
        tx_ready = 0;
        for (int i = 0; i < 5; i++) drive(1, 32'h30000, 1, 8'(8'h31 + i));
        idle(); tx_ready = 1;
        idle();
        @(posedge clk_in); #2; rst_in = 0; rdy_in = 0; cpu_wr = 0;
        @(negedge clk_in);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_count", 32'(dut.count), 0);
        chk("rst_cpu_din", 32'(cpu_din), 0);
        chk("rst_done", 32'(program_done), 0);
        @(posedge clk_in); #2; rst_in = 1;

        // 2: zero bytes are never emitted
        txlog.delete(); tx_ready = 1;
        drive(1, 32'h30000, 1, 8'h41);
        drive(1, 32'h30000, 1, 8'h00);
        drive(1, 32'h30000, 1, 8'h42);
        repeat (5) idle();
        @(negedge clk_in);
        chk("t2_len", 32'(txlog.size()), 2);
        if (txlog.size() == 2) begin
            chk("t2_b0", 32'(txlog[0]), 32'h41);
            chk("t2_b1", 32'(txlog[1]), 32'h42);
        end

        // 3: near-full flag, overflow, full drain
        do_reset(); tx_ready = 0;
        for (int i = 1; i <= 14; i++) drive(1, 32'h30000, 1, 8'(8'h60 + i));
        idle();
        @(negedge clk_in);
        chk("t3_full14", 32'(io_buffer_full), 1);
        chk("t3_count14", 32'(dut.count), 14);
        for (int i = 15; i <= 17; i++) drive(1, 32'h30000, 1, 8'(8'h60 + i));
        idle();
        @(negedge clk_in);
        chk("t3_ovf", 32'(dut.ovf), 1);
        chk("t3_count16", 32'(dut.count), 16);
        txlog.delete(); tx_ready = 1;
        n = 0;
        while (tx_valid && n < 40) begin idle(); n++; @(negedge clk_in); end
        chk("t3_drain_timeout", 32'(n < 40), 1);
        chk("t3_drained", 32'(txlog.size()), 16);
        if (txlog.size() == 16) begin
            chk("t3_first", 32'(txlog[0]), 32'h61);
            chk("t3_last", 32'(txlog[15]), 32'h70);
        end

        // 4: counter snapshot, stalled cycles excluded
        do_reset();
        for (int i = 0; i < 1000; i++) drive(i % 10 != 9, 32'h0, 0, 8'h00);
        drive(1, 32'h30004, 0, 0);
        drive(1, 32'h30005, 0, 0); @(negedge clk_in); b0 = cpu_din;
        drive(1, 32'h30006, 0, 0); @(negedge clk_in); b1 = cpu_din;
        drive(1, 32'h30007, 0, 0); @(negedge clk_in); b2 = cpu_din;
        idle();                    @(negedge clk_in); b3 = cpu_din;
        chk("t4_counter", {b3, b2, b1, b0}, 32'd900);

        // 5: RX read with and without a byte available
        rx_valid = 1; rx_data = 8'h5A;
        drive(1, 32'h30000, 0, 0); rx_valid = 1; rx_data = 8'h5A;
        @(negedge clk_in);
        chk("t5_pop", 32'(rx_pop), 1);
        idle(); rx_valid = 0;
        @(negedge clk_in);
        chk("t5_din", 32'(cpu_din), 32'h5A);
        chk("t5_nopop", 32'(rx_pop), 0);
        drive(1, 32'h30000, 0, 0);
        @(negedge clk_in);
        chk("t5_pop_empty", 32'(rx_pop), 0);
        idle();
        @(negedge clk_in);
        chk("t5_din_empty", 32'(cpu_din), 0);

        // 6: stop write, terminator, program_done
        do_reset(); tx_ready = 0; txlog.delete();
        for (int i = 1; i <= 3; i++) drive(1, 32'h30000, 1, 8'(i));
        drive(1, 32'h30004, 1, 8'h00);
        idle(); tx_ready = 1;
        n = 0;
        while (!program_done && n < 50) begin idle(); n++; @(negedge clk_in); end
        chk("t6_done_timeout", 32'(n < 50), 1);
        chk("t6_len", 32'(txlog.size()), 4);
        if (txlog.size() == 4) begin
            chk("t6_first", 32'(txlog[0]), 1);
            chk("t6_term", 32'(txlog[3]), 0);
        end
        drive(1, 32'h30000, 1, 8'h43);
        idle();
        @(negedge clk_in);
        chk("t6_ignored", 32'(tx_valid), 0);
        chk("t6_done_hold", 32'(program_done), 1);

        // Randomized traffic in three segments
        for (int s = 0; s < 3; s++) begin
            do_reset();
            for (int i = 0; i < 1000; i++) begin
                @(posedge clk_in); #2;
                rdy_in   = $urandom_range(0, 99) < 85;
                cpu_wr   = $urandom_range(0, 1);
                cpu_dout = ($urandom_range(0, 99) < 15) ? 8'h00 : 8'($urandom);
                r = $urandom_range(0, 99);
                if (r < 40) cpu_a = {$urandom} & 32'hFFFE_FFFF;
                else if (r < 65) cpu_a = 32'h30000;
                else if (r < 90) begin
                    cpu_a = 32'h30004 + $urandom_range(0, 3);
                    if (cpu_wr && cpu_a[1:0] == 0 && $urandom_range(0, 30) != 0) cpu_a = 32'h30005;
                end else cpu_a = 32'h30008 + $urandom_range(0, 255);
                cpu_a[31:18] = 14'($urandom);
                tx_ready = $urandom_range(0, 99) < 60;
                rx_valid = $urandom_range(0, 1);
                rx_data  = 8'($urandom);
                ram_dout = 8'($urandom);
            end
        end
        idle();
        @(negedge clk_in);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
